codificador_op: RTL and testbench

- Encoder counterpart to the ALU operation decoder: collects one-hot operation requests (bit0=AND, bit1=OR, bit2=NAND, bit3=XOR) from up to four requesters.
- Encodes them one at a time into a 2-bit operation selector, and presents each selector downstream on a valid/ready handshake.
- Sits in front of the operation decoder; its selector/valid pair drives the decoder's selector/enable.

---
 rtl/codificador_op_if.sv | 24 ++
 rtl/codificador_op.sv | 92 +++++++++
 tb/tb_codificador_op.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/codificador_op_if.sv
// Request/selector bundle between the requesters, the operation encoder
// and the downstream operation decoder.
interface codificador_op_if;
  logic       cod_enable;
  logic [3:0] cod_req_in;
  logic       cod_ready;
  logic       cod_clr_ovf;
  logic       cod_valid;
  logic [1:0] cod_selector;
  logic [3:0] cod_pending;
  logic       cod_overflow;

  // Encoder side: consumes requests and ready, produces selector/valid and status.
  modport slave (
    input  cod_enable, cod_req_in, cod_ready, cod_clr_ovf,
    output cod_valid, cod_selector, cod_pending, cod_overflow
  );

  // Environment side: drives requests and downstream ready.
  modport master (
    output cod_enable, cod_req_in, cod_ready, cod_clr_ovf,
    input  cod_valid, cod_selector, cod_pending, cod_overflow
  );
endinterface

// File: rtl/codificador_op.sv
// Round-robin encoder: latches one-hot operation requests and issues them one
// at a time as a 2-bit selector on a valid/ready handshake.
module codificador_op (
  input  logic             clk,
  input  logic             rst_n,
  codificador_op_if.slave  cod,
  output logic             dbg_state,
  output logic [1:0]       dbg_ptr
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;

  logic       handshake;
  logic [3:0] clear;
  logic [3:0] pending_nxt;
  logic       ovf_set;
  logic       pick_any;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  // Handshake: a selector transfers on any rising edge where cod_valid and
  // cod_ready are both high; once raised, cod_valid and cod_selector stay put
  // until that transfer happens.
  always_comb begin
    handshake = cod.cod_valid & cod.cod_ready;
    clear     = 4'b0000;
    if (handshake) clear[cod.cod_selector] = 1'b1;
    pending_nxt = (cod.cod_pending & ~clear) | cod.cod_req_in;
    ovf_set     = |(cod.cod_req_in & cod.cod_pending & ~clear);
  end

  // Search ptr, ptr+1, ptr+2, ptr+3; iterating downward lets the nearest win.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = ptr;
    cand     = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (cod.cod_pending[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      ptr              <= 2'b00;
      cod.cod_valid    <= 1'b0;
      cod.cod_selector <= 2'b00;
      cod.cod_pending  <= 4'b0000;
      cod.cod_overflow <= 1'b0;
    end else begin
      cod.cod_pending <= pending_nxt;

      if (ovf_set)              cod.cod_overflow <= 1'b1;
      else if (cod.cod_clr_ovf) cod.cod_overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (cod.cod_enable && pick_any) begin
            cod.cod_selector <= pick_idx;
            cod.cod_valid    <= 1'b1;
            state            <= PRESENT;
          end
        end
        PRESENT: begin
          if (cod.cod_ready) begin
            ptr           <= cod.cod_selector + 2'd1;
            cod.cod_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          cod.cod_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = (state == PRESENT);
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_codificador_op.sv
// Bench for codificador_op: directed scenarios plus random traffic, every cycle
// compared against a behavioural request/grant model.
module tb_codificador_op;

  logic       clk;
  logic       rst_n;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  codificador_op_if bus ();

  codificador_op dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cod       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  bit m_pend[4];
  bit m_valid;
  int m_sel;
  int m_ptr;
  bit m_ovf;

  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit en, input logic [3:0] req, input bit rdy, input bit clr);
    bit np[4];
    bit hs;
    bit dup;
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0; m_sel = 0; m_ptr = 0; m_ovf = 0;
      return;
    end
    hs  = m_valid && rdy;
    dup = 0;
    for (int i = 0; i < 4; i++) begin
      bit cleared;
      cleared = hs && (m_sel == i);
      np[i] = (m_pend[i] && !cleared) || req[i];
      if (req[i] && m_pend[i] && !cleared) dup = 1;
    end
    if (dup) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (m_valid) begin
      if (rdy) begin
        m_ptr   = (m_sel + 1) % 4;
        m_valid = 0;
      end
    end else if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_valid && m_pend[(m_ptr + k) % 4]) begin
          m_sel   = (m_ptr + k) % 4;
          m_valid = 1;
        end
      end
    end
    foreach (np[i]) m_pend[i] = np[i];
  endtask

  task automatic compare_all();
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = m_pend[i];
    check("valid",    bus.cod_valid,    m_valid);
    if (m_valid) check("selector", bus.cod_selector, m_sel);
    check("pending",  bus.cod_pending,  p);
    check("overflow", bus.cod_overflow, m_ovf);
    check("ptr",      dbg_ptr,          m_ptr);
    check("state",    dbg_state,        m_valid);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit en, input logic [3:0] req, input bit rdy, input bit clr);
    bus.cod_enable  = en;
    bus.cod_req_in  = req;
    bus.cod_ready   = rdy;
    bus.cod_clr_ovf = clr;
    model_step(en, req, rdy, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cycle(1'b0, 4'b0000, 1'b0, 1'b0);
    cycle(1'b1, 4'b1111, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.cod_enable = 1'b0; bus.cod_req_in = 4'b0; bus.cod_ready = 1'b0; bus.cod_clr_ovf = 1'b0;
    apply_reset();
    check("rst_valid",   bus.cod_valid,    1'b0);
    check("rst_sel",     bus.cod_selector, 2'b00);
    check("rst_pending", bus.cod_pending,  4'b0000);
    check("rst_ovf",     bus.cod_overflow, 1'b0);

    // single request, two-edge latency, handshake clears it
    cycle(1, 4'b0100, 0, 0);
    check("s1_pend", bus.cod_pending, 4'b0100);
    check("s1_novalid", bus.cod_valid, 1'b0);
    cycle(1, 4'b0000, 1, 0);
    check("s1_valid", bus.cod_valid, 1'b1);
    check("s1_sel", bus.cod_selector, 2'b10);
    cycle(1, 4'b0000, 1, 0);
    check("s1_done_valid", bus.cod_valid, 1'b0);
    check("s1_done_pend", bus.cod_pending, 4'b0000);

    // round-robin over all four with ready held
    apply_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 9; i++) begin
      cycle(1, (i == 0) ? 4'b1111 : 4'b0000, 1, 0);
      if (bus.cod_valid) begin
        if (exp_q.size() == 0) check("rr_extra", bus.cod_selector, 2'bxx);
        else check("rr_sel", bus.cod_selector, exp_q.pop_front());
      end
    end
    check("rr_left", exp_q.size(), 0);
    check("rr_pend", bus.cod_pending, 4'b0000);
    check("rr_ovf", bus.cod_overflow, 1'b0);

    // backpressure and overflow
    apply_reset();
    cycle(1, 4'b0010, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, (i == 2) ? 4'b0010 : 4'b0000, 0, 0);
      check("bp_valid", bus.cod_valid, 1'b1);
      check("bp_sel", bus.cod_selector, 2'b01);
    end
    check("bp_ovf", bus.cod_overflow, 1'b1);
    cycle(1, 4'b0000, 0, 1);
    check("bp_ovf_clr", bus.cod_overflow, 1'b0);
    cycle(1, 4'b0000, 1, 0);
    check("bp_drain", bus.cod_pending, 4'b0000);

    // same-cycle clear and new request on bit 3
    apply_reset();
    cycle(1, 4'b1000, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    check("sc_sel", bus.cod_selector, 2'b11);
    cycle(1, 4'b1000, 1, 0);
    check("sc_pend", bus.cod_pending, 4'b1000);
    check("sc_ovf", bus.cod_overflow, 1'b0);
    cycle(1, 4'b0000, 0, 0);
    check("sc_reissue_v", bus.cod_valid, 1'b1);
    check("sc_reissue_s", bus.cod_selector, 2'b11);
    cycle(1, 4'b0000, 1, 0);

    // enable gating
    apply_reset();
    cycle(0, 4'b0001, 0, 0);
    cycle(0, 4'b0000, 0, 0);
    check("en_pend", bus.cod_pending, 4'b0001);
    check("en_hold", bus.cod_valid, 1'b0);
    cycle(1, 4'b0000, 0, 0);
    check("en_valid", bus.cod_valid, 1'b1);
    check("en_sel", bus.cod_selector, 2'b00);
    cycle(0, 4'b0000, 0, 0);
    check("en_keep", bus.cod_valid, 1'b1);
    cycle(0, 4'b0000, 1, 0);

    // reset mid-handshake
    apply_reset();
    cycle(1, 4'b1010, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    check("mr_valid", bus.cod_valid, 1'b1);
    rst_n = 1'b0;
    cycle(1, 4'b0000, 0, 0);
    rst_n = 1'b1;
    check("mr_pend", bus.cod_pending, 4'b0000);
    check("mr_ptr", dbg_ptr, 2'b00);
    cycle(1, 4'b1001, 0, 0);
    cycle(1, 4'b0000, 0, 0);
    check("mr_first", bus.cod_selector, 2'b00);
    cycle(1, 4'b0000, 1, 0);
    cycle(1, 4'b0000, 1, 0);
    cycle(1, 4'b0000, 1, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] req;
      req   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      cycle(($urandom_range(0, 4) != 0), req, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0));
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
